// File: rtl/mem_arbiter.sv
// Round-robin arbiter that merges instruction-cache refills and data-cache
// refills/write-backs onto one block-wide backing-memory port.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERV_D = 3'd1,
        SERV_I = 3'd2,
        DONE_D = 3'd3,
        DONE_I = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              last_r;
    logic              seen_busy_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic              d_req_s;
    logic              serving_s;
    logic              done_s;
    logic              grant_d_s;
    logic              grant_i_s;

    assign d_req_s = d_read | d_write;

    // Completion needs a busy phase first, so a memory that answers before
    // reacting to the strobe cannot complete a transaction early.
    always_comb begin
        serving_s = (state_r == SERV_D) || (state_r == SERV_I);
        done_s    = serving_s && seen_busy_r && !mem_busywait;
    end

    // Next-state logic; on a tie the side that was not granted last wins.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (d_req_s && (!i_read || last_r)) begin
                    state_nxt_s = SERV_D;
                end else if (i_read) begin
                    state_nxt_s = SERV_I;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SERV_D: begin
                if (done_s) begin
                    state_nxt_s = DONE_D;
                end else begin
                    state_nxt_s = SERV_D;
                end
            end
            SERV_I: begin
                if (done_s) begin
                    state_nxt_s = DONE_I;
                end else begin
                    state_nxt_s = SERV_I;
                end
            end
            DONE_D:  state_nxt_s = IDLE;
            DONE_I:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grant decode from the chosen transition out of IDLE.
    always_comb begin
        grant_d_s = (state_r == IDLE) && (state_nxt_s == SERV_D);
        grant_i_s = (state_r == IDLE) && (state_nxt_s == SERV_I);
    end

    // State, latched request, registered memory strobes and readdata capture.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= IDLE;
            last_r      <= 1'b1;
            seen_busy_r <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
            i_rdata_r   <= {DATA_W{1'b0}};
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_d_s) begin
                addr_r      <= d_address;
                wdata_r     <= d_writedata;
                mem_read_r  <= ~d_write;
                mem_write_r <= d_write;
                seen_busy_r <= 1'b0;
            end else if (grant_i_s) begin
                addr_r      <= i_address;
                mem_read_r  <= 1'b1;
                mem_write_r <= 1'b0;
                seen_busy_r <= 1'b0;
            end else if (done_s) begin
                mem_read_r  <= 1'b0;
                mem_write_r <= 1'b0;
                last_r      <= (state_r == SERV_I);
                if (mem_read_r && (state_r == SERV_D)) begin
                    d_rdata_r <= mem_readdata;
                end
                if (mem_read_r && (state_r == SERV_I)) begin
                    i_rdata_r <= mem_readdata;
                end
            end else if (serving_s && mem_busywait) begin
                seen_busy_r <= 1'b1;
            end
        end
    end

    // A cache sees its grant as busywait dropping during its DONE cycle only.
    assign d_busywait    = d_req_s & (state_r != DONE_D);
    assign i_busywait    = i_read & (state_r != DONE_I);
    assign d_readdata    = d_rdata_r;
    assign i_readdata    = i_rdata_r;
    assign mem_read      = mem_read_r;
    assign mem_write     = mem_write_r;
    assign mem_address   = addr_r;
    assign mem_writedata = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    localparam logic [DW-1:0] PAT_A5   = {16{8'hA5}};
    localparam logic [DW-1:0] PAT_INSN = 128'h00130013_00130013_00930093_00930093;
    localparam logic [DW-1:0] PAT_T3   = 128'h11112222_33334444_55556666_77778888;
    localparam logic [DW-1:0] PAT_T4   = 128'hCAFEF00D_01234567_89ABCDEF_0F0F0F0F;
    localparam logic [DW-1:0] PAT_WB   = {4{32'hDEADBEEF}};
    localparam logic [DW-1:0] PAT_X    = 128'h99999999_88888888_77777777_66666666;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic d_read = 1'b0, d_write = 1'b0, i_read = 1'b0;
    logic [AW-1:0] d_address = '0, i_address = '0;
    logic [DW-1:0] d_writedata = '0, mem_readdata = '0;
    logic mem_busywait = 1'b0;
    logic [DW-1:0] d_readdata, i_readdata, mem_writedata;
    logic [AW-1:0] mem_address;
    logic d_busywait, i_busywait, mem_read, mem_write;

    int tests = 0;
    int fails = 0;
    int busy_len = 1;
    int busy_cnt = 0;
    int rd_cyc, wr_cyc, d_wait, i_wait;
    logic [AW-1:0] addr_log[$];
    logic [DW-1:0] wdata_log[$];
    bit prev_strobe = 1'b0;

    // Model state: what the arbiter is doing at transaction level.
    bit started = 1'b0;
    int m_phase = 0;          // 0 idle, 1 memory busy with a request, 2 handing back
    bit m_side = 1'b0;        // 0 data cache, 1 instruction cache
    bit m_last_i = 1'b1;
    bit m_seen = 1'b0;
    bit m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_dq = '0, m_iq = '0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_writedata(d_writedata), .d_readdata(d_readdata), .d_busywait(d_busywait),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata),
        .i_busywait(i_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: busy for busy_len cycles once a strobe is seen, then ready.
    always @(negedge CLK) begin
        if (mem_read | mem_write) begin
            mem_busywait = (busy_cnt < busy_len);
            busy_cnt++;
        end else begin
            mem_busywait = 1'b0;
            busy_cnt = 0;
        end
    end

    // Record the address and write block at the start of each memory transaction.
    always @(negedge CLK) begin
        if ((mem_read | mem_write) && !prev_strobe) begin
            addr_log.push_back(mem_address);
            wdata_log.push_back(mem_writedata);
        end
        prev_strobe = mem_read | mem_write;
    end

    // Transaction-level model advanced on each clock edge.
    always @(posedge CLK) begin
        started = 1'b1;
        if (RESET) begin
            m_phase = 0; m_last_i = 1'b1; m_seen = 1'b0; m_wr = 1'b0;
            m_addr = '0; m_wdata = '0; m_dq = '0; m_iq = '0;
        end else if (m_phase == 0) begin
            if (d_read | d_write | i_read) begin
                if (d_read | d_write) m_side = i_read && !m_last_i;
                else m_side = 1'b1;
                m_phase = 1;
                m_seen = 1'b0;
                if (m_side) begin
                    m_addr = i_address; m_wr = 1'b0;
                end else begin
                    m_addr = d_address; m_wdata = d_writedata; m_wr = d_write;
                end
            end
        end else if (m_phase == 1) begin
            if (m_seen && !mem_busywait) begin
                if (!m_wr) begin
                    if (m_side) m_iq = mem_readdata;
                    else m_dq = mem_readdata;
                end
                m_last_i = m_side;
                m_phase = 2;
            end else if (mem_busywait) begin
                m_seen = 1'b1;
            end
        end else begin
            m_phase = 0;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge CLK) begin
        if (started) begin
            check("mem_read", mem_read, (m_phase == 1) && !m_wr);
            check("mem_write", mem_write, (m_phase == 1) && m_wr);
            check("mem_address", mem_address, m_addr);
            check("mem_writedata", mem_writedata, m_wdata);
            check("d_readdata", d_readdata, m_dq);
            check("i_readdata", i_readdata, m_iq);
            check("d_busywait", d_busywait, (d_read | d_write) && !(m_phase == 2 && !m_side));
            check("i_busywait", i_busywait, i_read && !(m_phase == 2 && m_side));
        end
    end

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    // Serve nd data and ni instruction requests, holding each request until
    // it has been granted that many times.
    task automatic run(input int nd, input int ni, input bit wr,
                       input logic [AW-1:0] da, input logic [AW-1:0] ia,
                       input logic [DW-1:0] dd, input logic [DW-1:0] md, input int bl);
        int cyc;
        @(posedge CLK); #1;
        d_read = (nd > 0) && !wr; d_write = (nd > 0) && wr; i_read = (ni > 0);
        d_address = da; i_address = ia; d_writedata = dd; mem_readdata = md; busy_len = bl;
        rd_cyc = 0; wr_cyc = 0; d_wait = 0; i_wait = 0; cyc = 0;
        while ((nd > 0 || ni > 0) && cyc < 1000) begin
            @(negedge CLK);
            cyc++;
            if (mem_read) rd_cyc++;
            if (mem_write) wr_cyc++;
            if (d_busywait) d_wait++;
            if (i_busywait) i_wait++;
            if (nd > 0 && !d_busywait) nd--;
            if (ni > 0 && !i_busywait) ni--;
            @(posedge CLK); #1;
            if (nd == 0) begin d_read = 1'b0; d_write = 1'b0; end
            if (ni == 0) i_read = 1'b0;
        end
        if (cyc >= 1000) begin
            tests++; fails++;
            $display("FAIL watchdog: no completion after %0d cycles (required < 1000)", cyc);
        end
    endtask

    initial begin
        int nb, cyc;
        do_reset();
        @(negedge CLK);
        check("reset_mem_read", mem_read, 1'b0);
        check("reset_d_readdata", d_readdata, '0);
        check("reset_mem_address", mem_address, '0);

        // Data read, 5 busy cycles.
        addr_log.delete(); wdata_log.delete();
        run(1, 0, 1'b0, 28'h0000010, 28'h0, '0, PAT_A5, 5);
        check("t1_mem_read_cycles", rd_cyc, 6);
        check("t1_d_wait_cycles", d_wait, 7);
        check("t1_i_wait_cycles", i_wait, 0);
        check("t1_d_readdata", d_readdata, PAT_A5);
        check("t1_address", addr_log.size() == 1 ? addr_log[0] : '1, 28'h0000010);

        // Instruction read.
        run(0, 1, 1'b0, 28'h0, 28'h0000004, '0, PAT_INSN, 3);
        check("t2_i_readdata", i_readdata, PAT_INSN);
        check("t2_mem_write_cycles", wr_cyc, 0);
        check("t2_d_readdata_kept", d_readdata, PAT_A5);

        // Simultaneous requests straight after reset: D first.
        do_reset();
        addr_log.delete(); wdata_log.delete();
        run(1, 1, 1'b0, 28'h0000040, 28'h0000080, '0, PAT_T3, 2);
        check("t3_grants", addr_log.size(), 2);
        check("t3_first_d", addr_log.size() > 0 ? addr_log[0] : '1, 28'h0000040);
        check("t3_second_i", addr_log.size() > 1 ? addr_log[1] : '1, 28'h0000080);
        check("t3_d_wait_cycles", d_wait, 4);
        check("t3_i_wait_cycles", i_wait, 9);

        // Round-robin under continuous requests.
        addr_log.delete(); wdata_log.delete();
        run(2, 2, 1'b0, 28'h0000100, 28'h0000200, '0, PAT_T4, 1);
        check("t4_grants", addr_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4_grant%0d", k), addr_log.size() > k ? addr_log[k] : '1,
                  (k % 2 == 0) ? 28'h0000100 : 28'h0000200);
        end
        check("t4_d_readdata", d_readdata, PAT_T4);

        // Write-back.
        addr_log.delete(); wdata_log.delete();
        run(1, 0, 1'b1, 28'h00000FF, 28'h0, PAT_WB, PAT_X, 3);
        check("t5_mem_write_cycles", wr_cyc, 4);
        check("t5_mem_read_cycles", rd_cyc, 0);
        check("t5_address", addr_log.size() == 1 ? addr_log[0] : '1, 28'h00000FF);
        check("t5_writedata", wdata_log.size() == 1 ? wdata_log[0] : '0, PAT_WB);
        check("t5_d_readdata_kept", d_readdata, PAT_T4);

        // Reset in the 3rd busy cycle of a data read.
        @(posedge CLK); #1;
        d_read = 1'b1; d_address = 28'h0000020; mem_readdata = PAT_X; busy_len = 5;
        nb = 0; cyc = 0;
        while (nb < 3 && cyc < 100) begin
            @(negedge CLK); #1;
            cyc++;
            if (mem_busywait) nb++;
        end
        check("t6_reached_busy", nb, 3);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        i_read = 1'b1; i_address = 28'h0000030;
        @(negedge CLK);
        check("t6_mem_read_dropped", mem_read, 1'b0);
        check("t6_d_readdata_cleared", d_readdata, '0);
        addr_log.delete(); wdata_log.delete();
        run(1, 1, 1'b0, 28'h0000020, 28'h0000030, '0, PAT_T3, 2);
        check("t6_first_d", addr_log.size() > 0 ? addr_log[0] : '1, 28'h0000020);
        check("t6_second_i", addr_log.size() > 1 ? addr_log[1] : '1, 28'h0000030);

        repeat (2) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
